// File: rtl/demux_rr_distributor_if.sv
// Handshake bundle for the 1-to-4 round-robin distributor: upstream word stream,
// four downstream lanes, and the pointer/counter status outputs.
interface demux_rr_distributor_if #(
    parameter int WIDTH = 8
);
    logic                 en_n;
    logic                 mode;
    logic [WIDTH-1:0]     in_data;
    logic [1:0]           in_sel;
    logic                 in_valid;
    logic                 in_ready;
    logic [4*WIDTH-1:0]   out_data;
    logic [3:0]           out_valid;
    logic [3:0]           out_ready;
    logic [1:0]           rr_ptr;
    logic [15:0]          xfer_cnt;

    modport master (
        output en_n, mode, in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, rr_ptr, xfer_cnt
    );

    modport slave (
        input  en_n, mode, in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, rr_ptr, xfer_cnt
    );
endinterface

// File: rtl/demux_rr_distributor.sv
// Distributes each accepted word to one of four one-entry lane registers (RR or addressed), 1-cycle latency.
// Back-pressure is per target lane: a full lane that is not draining stalls input, never skipped.
module demux_rr_distributor #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    demux_rr_distributor_if.slave   bus
);
    logic [1:0]         w_tgt;
    logic               w_in_ready;
    logic               w_accept;

    logic [4*WIDTH-1:0] r_out_data;
    logic [3:0]         r_out_valid;
    logic [1:0]         r_rr_ptr;
    logic [15:0]        r_xfer_cnt;

    assign w_tgt      = bus.mode ? bus.in_sel : r_rr_ptr;
    // A lane draining this cycle can take a new word on the same edge.
    assign w_in_ready = ~bus.en_n & (~r_out_valid[w_tgt] | bus.out_ready[w_tgt]);
    assign w_accept   = bus.in_valid & w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_accept && (w_tgt == 2'(i))) begin
                    r_out_data[i*WIDTH +: WIDTH] <= bus.in_data;
                    r_out_valid[i]               <= 1'b1;
                end else if (r_out_valid[i] && bus.out_ready[i]) begin
                    r_out_valid[i]               <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= 2'd0;
        end else if (w_accept && !bus.mode) begin
            r_rr_ptr <= r_rr_ptr + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_cnt <= 16'd0;
        end else if (w_accept && (r_xfer_cnt != 16'hFFFF)) begin
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.rr_ptr    = r_rr_ptr;
    assign bus.xfer_cnt  = r_xfer_cnt;
endmodule

// File: doc/demux_rr_distributor.md
# demux_rr_distributor

Registered, handshaked 1-to-4 distributor that feeds the four-way demultiplexer output lanes from a single upstream word stream. Each accepted input word goes to one of four output channels, chosen by an internal round-robin pointer or by an explicit per-word select. Each channel holds the word in a one-entry output register until its consumer takes it. The block turns the combinational 1x4 routing into a flow-controlled pipeline stage with back-pressure per channel.

## Interface
- WIDTH, 8, data word width in bits

- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- en_n  input  1  active-low enable; when high, no new input is accepted
- mode  input  1  0 = round-robin routing, 1 = addressed routing using in_sel
- in_data  input  WIDTH  input word
- in_sel  input  2  target channel when mode=1; ignored when mode=0
- in_valid  input  1  input word present
- in_ready  output  1  block can accept the input word this cycle
- out_data  output  4*WIDTH  channel i word at bits [i*WIDTH +: WIDTH]
- out_valid  output  4  per-channel word-present flag
- out_ready  input  4  per-channel consumer ready
- rr_ptr  output  2  current round-robin pointer
- xfer_cnt  output  16  count of accepted input words, saturating

## Operation
- Target channel: tgt = mode ? in_sel : rr_ptr.
- in_ready = ~en_n & (~out_valid[tgt] | out_ready[tgt]). This is combinational from en_n, mode, in_sel, rr_ptr, out_valid and out_ready. The same-cycle drain of the target slot allows a new accept.
- accept = in_valid & in_ready.
- On accept:
  - slot tgt loads in_data and out_valid[tgt] is set.
  - xfer_cnt increments, holding at 16'hFFFF.
- rr_ptr advances 0→1→2→3→0 only on an accept with mode=0. It holds on an accept with mode=1, when idle, and while en_n=1.
- Channel i drain: if out_valid[i] & out_ready[i] and there is no accept into i, out_valid[i] clears on the next edge. If there is an accept into i in the same cycle, out_valid[i] stays 1 and the data is replaced by the new word.
- Channels drain independently of en_n. en_n only gates acceptance.
- A mode change takes effect in the same cycle for tgt/in_ready. rr_ptr is preserved across mode changes.
- out_data[i] is stable while out_valid[i] & ~out_ready[i]. It holds its last value after a drain; this value is don't-care to consumers.
- Upstream must hold in_data/in_sel stable while in_valid & ~in_ready. The block does not check this.
- No internal state machine beyond rr_ptr. Each channel is an independent 2-state full/empty flag.

## Timing
- Reset (rst_n low, asynchronous): out_valid=4'b0000, out_data=0, rr_ptr=0, xfer_cnt=0. in_ready follows combinationally, which gives ~en_n.
- Reset deassertion: the first accept is possible on the first rising edge with rst_n=1.
- Latency: word accepted at edge N → out_valid[tgt]=1 and out_data valid after edge N.
- Throughput: 1 word/cycle when each target slot is empty or draining in the same cycle.
- Full slot: if out_valid[tgt]=1 and out_ready[tgt]=0, then in_ready=0 and rr_ptr holds. In round-robin mode there is no skipping to another channel; order is strictly 0,1,2,3.
- Reset mid-transfer: all buffered words are discarded and the counter is cleared immediately, regardless of clk.
- xfer_cnt wrap: never wraps. It holds at 65535 for further accepts.

## Test plan
- Reset, en_n=0, mode=0, all out_ready=0, four words A1,B2,C3,D4 with in_valid=1 → channels 0..3 hold A1,B2,C3,D4, out_valid=4'hF, rr_ptr=0, in_ready=0 on the 5th cycle, xfer_cnt=4.
- From that state, raise out_ready[0] only with word E5 waiting → same-cycle accept; channel 0 holds E5, out_valid[0] stays 1, rr_ptr=1, xfer_cnt=5.
- mode=1, in_sel=2, channel 2 empty, 3 back-to-back words with out_ready[2]=1 → all three appear in order on channel 2, one per cycle, and rr_ptr is unchanged.
- en_n=1 with in_valid=1 and all slots empty → in_ready=0, no out_valid set, xfer_cnt unchanged. Existing full slots still drain when out_ready is asserted.
- Assert rst_n low asynchronously between edges with out_valid=4'hF, rr_ptr=3 → out_valid=0, rr_ptr=0, xfer_cnt=0 immediately.
- Force 65537 accepts (all out_ready=1) → xfer_cnt=16'hFFFF, no wrap.
